mem_stage: RTL

Memory-access pipeline stage between EX and WB. It registers the EX-to-MEM bus and collects synchronous data-SRAM read data for the instruction it holds. It sign- or zero-extends load bytes and halfwords and sends the write-back result to WB. It also drives the MEM-to-ID forwarding bus. A hold buffer keeps SRAM read data valid while the stage is stalled.

---
 rtl/mem_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX bus, extends SRAM load data and drives the WB/ID buses.
// Optional misaligned-load detection is enabled with `define MEM_ALIGN_CHK_EN.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 80,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_ID_FW = 38,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_FW-1:0] mem_to_id_bus,
  output logic                    mem_adel
);

  logic [EX_TO_MEM_WD-1:0] r_bus;
  logic                    r_fresh;
  logic                    r_hold_valid;
  logic [31:0]             r_hold_data;

  logic        w_bubble;
  logic        w_update;
  logic [3:0]  w_readen;
  logic [31:0] w_pc;
  logic        w_ram_en;
  logic [3:0]  w_ram_wen;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_ex_result;
  logic        w_load;
  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  logic        w_is_lw;
  logic        w_is_lh_any;
  logic        w_adel;
  logic        w_rf_we_out;
  logic        w_unused;

  assign w_bubble = stall[3] & ~stall[4];
  assign w_update = ~(stall[3] & stall[4]);
  assign w_unused = ^{stall[STALL_WD-1:5], stall[2:0]};

  // Any R update (load or bubble) invalidates the hold buffer; only the first
  // stalled edge after an update captures SRAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus        <= '0;
      r_fresh      <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_update) begin
      r_bus        <= w_bubble ? '0 : ex_to_mem_bus;
      r_fresh      <= 1'b1;
      r_hold_valid <= 1'b0;
    end else begin
      r_fresh <= 1'b0;
      if (r_fresh) begin
        r_hold_data  <= data_sram_rdata;
        r_hold_valid <= 1'b1;
      end
    end
  end

  assign w_readen     = r_bus[79:76];
  assign w_pc         = r_bus[75:44];
  assign w_ram_en     = r_bus[43];
  assign w_ram_wen    = r_bus[42:39];
  assign w_sel_rf_res = r_bus[38];
  assign w_rf_we      = r_bus[37];
  assign w_rf_waddr   = r_bus[36:32];
  assign w_ex_result  = r_bus[31:0];

  assign w_load  = w_ram_en & (w_ram_wen == 4'b0000);
  assign w_rdata = r_hold_valid ? r_hold_data : data_sram_rdata;

  always_comb begin
    w_byte = '0;
    case (w_ex_result[1:0])
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
  end

  assign w_half = w_ex_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_load_data = w_rdata;
    w_is_lw     = 1'b0;
    w_is_lh_any = 1'b0;
    case (w_readen)
      4'b0001: w_load_data = {{24{w_byte[7]}}, w_byte};
      4'b0010: w_load_data = {24'h0, w_byte};
      4'b0011: begin
        w_load_data = {{16{w_half[15]}}, w_half};
        w_is_lh_any = 1'b1;
      end
      4'b0100: begin
        w_load_data = {16'h0, w_half};
        w_is_lh_any = 1'b1;
      end
      default: w_is_lw = 1'b1;
    endcase
  end

  assign w_rf_wdata = (w_sel_rf_res & w_load) ? w_load_data : w_ex_result;

`ifdef MEM_ALIGN_CHK_EN
  assign w_adel = w_load & ((w_is_lw & (w_ex_result[1:0] != 2'b00)) |
                            (w_is_lh_any & w_ex_result[0]));
`else
  logic w_unused_chk;
  assign w_unused_chk = w_is_lw ^ w_is_lh_any;
  assign w_adel       = 1'b0;
`endif

  assign w_rf_we_out   = w_rf_we & ~w_adel;
  assign mem_adel      = w_adel;
  assign mem_to_wb_bus = {w_pc, w_rf_we_out, w_rf_waddr, w_rf_wdata};
  assign mem_to_id_bus = {w_rf_we_out, w_rf_waddr, w_rf_wdata};

endmodule
